// File: rtl/lif_alu_driver_if.sv
// Bundles the weight handshake and the ALU operand/result bus.
// "master" is the neuron controller; "slave" is the weight producer plus the shared ALU.
interface lif_alu_driver_if #(
    parameter int WIDTH = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_weight;
    logic signed [WIDTH-1:0] alu_x;
    logic signed [WIDTH-1:0] alu_y;
    logic signed [WIDTH-1:0] alu_z;
    logic                    alu_s;
    logic                    alu_zr;
    logic                    alu_cy;
    logic                    alu_v;
    logic                    alu_p;

    modport master (
        input  in_valid, in_weight, alu_z, alu_s, alu_zr, alu_cy, alu_v, alu_p,
        output in_ready, alu_x, alu_y
    );

    modport slave (
        output in_valid, in_weight, alu_z, alu_s, alu_zr, alu_cy, alu_v, alu_p,
        input  in_ready, alu_x, alu_y
    );
endinterface

// File: rtl/lif_alu_driver.sv
// Leaky integrate-and-fire neuron controller driving a shared 16-bit signed adder.
// Each accepted weight takes a leak pass and an integrate pass through the ALU.
module lif_alu_driver #(
    parameter int                      WIDTH      = 16,
    parameter logic signed [WIDTH-1:0] THRESH     = 16'sd1000,
    parameter logic signed [WIDTH-1:0] V_RESET    = 16'sd0,
    parameter int                      LEAK_SHIFT = 4,
    parameter int                      REFRACT    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lif_alu_driver_if.master        bus,
    output logic                    spike,
    output logic signed [WIDTH-1:0] vmem
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAK,
        S_INTEG,
        S_REFRACT
    } state_t;

    localparam logic [3:0]              REFRACT_CNT = 4'(REFRACT);
    localparam logic signed [WIDTH-1:0] SAT_MAX     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN     = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                  state, state_n;
    logic signed [WIDTH-1:0] vmem_n;
    logic signed [WIDTH-1:0] weight, weight_n;
    logic signed [WIDTH-1:0] leak_term;
    logic signed [WIDTH-1:0] sat_z;
    logic [3:0]              count, count_n;
    logic                    spike_n;
    logic                    armed;
    logic                    unused_flags;

    assign unused_flags = bus.alu_s ^ bus.alu_zr ^ bus.alu_cy ^ bus.alu_p;
    assign leak_term    = -(vmem >>> LEAK_SHIFT);

    // Overflow only happens when both operands share a sign, so X's sign picks the rail.
    assign sat_z = bus.alu_v ? (bus.alu_x[WIDTH-1] ? SAT_MIN : SAT_MAX) : bus.alu_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            vmem   <= '0;
            spike  <= 1'b0;
            weight <= '0;
            count  <= '0;
            armed  <= 1'b0;
        end else begin
            state  <= state_n;
            vmem   <= vmem_n;
            spike  <= spike_n;
            weight <= weight_n;
            count  <= count_n;
            armed  <= 1'b1;
        end
    end

    // Operand drive is kept apart from the result path so the ALU loop stays acyclic.
    always_comb begin
        bus.in_ready = 1'b0;
        bus.alu_x    = '0;
        bus.alu_y    = '0;
        case (state)
            S_IDLE:  bus.in_ready = armed;
            S_LEAK: begin
                bus.alu_x = vmem;
                bus.alu_y = leak_term;
            end
            S_INTEG: begin
                bus.alu_x = vmem;
                bus.alu_y = weight;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n  = state;
        vmem_n   = vmem;
        spike_n  = 1'b0;
        weight_n = weight;
        count_n  = count;
        case (state)
            S_IDLE: begin
                if (bus.in_valid && armed) begin
                    weight_n = bus.in_weight;
                    state_n  = S_LEAK;
                end
            end
            S_LEAK: begin
                vmem_n  = sat_z;
                state_n = S_INTEG;
            end
            S_INTEG: begin
                if (sat_z >= THRESH) begin
                    vmem_n  = V_RESET;
                    spike_n = 1'b1;
                    count_n = REFRACT_CNT;
                    state_n = (REFRACT_CNT == 4'd0) ? S_IDLE : S_REFRACT;
                end else begin
                    vmem_n  = sat_z;
                    state_n = S_IDLE;
                end
            end
            S_REFRACT: begin
                count_n = count - 4'd1;
                if (count == 4'd1) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_lif_alu_driver.sv
// Directed bench for lif_alu_driver: a weight table walked from reset, plus
// hand-written sequences for leak sign, refractory timing and mid-update reset.
module tb_lif_alu_driver;
    logic               clk;
    logic               rst_n;
    logic               spike;
    logic signed [15:0] vmem;
    logic [16:0]        wide_sum;
    int                 checks;
    int                 passed;

    lif_alu_driver_if #(.WIDTH(16)) bus ();

    lif_alu_driver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master),
        .spike (spike),
        .vmem  (vmem)
    );

    // Reference adder standing in for the shared ALU: wrapped sum plus flags.
    assign wide_sum   = {1'b0, bus.alu_x} + {1'b0, bus.alu_y};
    assign bus.alu_z  = wide_sum[15:0];
    assign bus.alu_cy = wide_sum[16];
    assign bus.alu_s  = wide_sum[15];
    assign bus.alu_zr = (wide_sum[15:0] == 16'd0);
    assign bus.alu_p  = ^wide_sum[15:0];
    assign bus.alu_v  = (bus.alu_x[15] == bus.alu_y[15]) && (wide_sum[15] != bus.alu_x[15]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] weight;
        logic signed [15:0] exp_vmem;
        logic               exp_spike;
    } vec_t;

    vec_t vecs[10];

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_weight = '0;
        #1;
        check_output("reset_vmem", vmem, 0);
        check_output("reset_spike", spike, 0);
        check_output("reset_alu_x", bus.alu_x, 0);
        check_output("reset_alu_y", bus.alu_y, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("reset_release_ready", bus.in_ready, 1);
    endtask

    // Waits (bounded) for in_ready, hands over one weight, returns sampled in cycle 3.
    task automatic apply_stimulus(input logic signed [15:0] w);
        int waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!bus.in_ready) begin
            check_output("ready_timeout", bus.in_ready, 1);
            return;
        end
        bus.in_valid  = 1'b1;
        bus.in_weight = w;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        passed = 0;

        vecs[0] = '{16'sd100,    16'sd100,    1'b0};
        vecs[1] = '{16'sd200,    16'sd294,    1'b0};
        vecs[2] = '{16'sd800,    16'sd0,      1'b1};
        vecs[3] = '{-16'sd20000, -16'sd20000, 1'b0};
        vecs[4] = '{-16'sd20000, -16'sd32768, 1'b0};
        vecs[5] = '{16'sd0,      -16'sd30720, 1'b0};
        vecs[6] = '{16'sd32767,  16'sd0,      1'b1};
        vecs[7] = '{16'sd1000,   16'sd0,      1'b1};
        vecs[8] = '{16'sd999,    16'sd999,    1'b0};
        vecs[9] = '{16'sd1,      16'sd938,    1'b0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].weight);
            check_output($sformatf("vec%0d_vmem", i), vmem, vecs[i].exp_vmem);
            check_output($sformatf("vec%0d_spike", i), spike, vecs[i].exp_spike);
            check_output($sformatf("vec%0d_ready", i), bus.in_ready, vecs[i].exp_spike ? 0 : 1);
        end

        // Single spike: one-cycle pulse, then two refractory cycles.
        do_reset();
        apply_stimulus(16'sd1000);
        check_output("fire_spike", spike, 1);
        check_output("fire_vmem", vmem, 0);
        check_output("fire_ready_c3", bus.in_ready, 0);
        @(posedge clk);
        #1;
        check_output("fire_spike_drop", spike, 0);
        check_output("fire_ready_c4", bus.in_ready, 0);
        @(posedge clk);
        #1;
        check_output("fire_ready_c5", bus.in_ready, 1);

        // Arithmetic shift of a small negative potential.
        do_reset();
        apply_stimulus(-16'sd16);
        check_output("neg_setup_vmem", vmem, -16);
        bus.in_valid  = 1'b1;
        bus.in_weight = 16'sd0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_output("neg_leak_x", bus.alu_x, -16);
        check_output("neg_leak_y", bus.alu_y, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("neg_leak_vmem", vmem, -15);

        // Reset arriving during INTEG must discard the update.
        do_reset();
        apply_stimulus(16'sd100);
        check_output("abort_setup_vmem", vmem, 100);
        bus.in_valid  = 1'b1;
        bus.in_weight = 16'sd500;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_output("abort_leak_y", bus.alu_y, -6);
        @(posedge clk);
        #1;
        check_output("abort_integ_x", bus.alu_x, 94);
        check_output("abort_integ_y", bus.alu_y, 500);
        rst_n = 1'b0;
        #1;
        check_output("abort_vmem", vmem, 0);
        check_output("abort_spike", spike, 0);
        check_output("abort_alu_x", bus.alu_x, 0);
        check_output("abort_alu_y", bus.alu_y, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("abort_ready", bus.in_ready, 1);
        check_output("abort_vmem_after", vmem, 0);

        // in_valid held through refractory is taken only on the first IDLE cycle.
        do_reset();
        apply_stimulus(16'sd1000);
        check_output("hold_spike", spike, 1);
        bus.in_valid  = 1'b1;
        bus.in_weight = 16'sd50;
        @(posedge clk);
        #1;
        check_output("hold_ready_c4", bus.in_ready, 0);
        @(posedge clk);
        #1;
        check_output("hold_ready_c5", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_output("hold_ready_c6", bus.in_ready, 0);
        check_output("hold_vmem_c6", vmem, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("hold_vmem_c8", vmem, 50);
        check_output("hold_ready_c8", bus.in_ready, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
